// File: rtl/matrix_mul_q_pkg.sv
// Shared types, state codes and helpers for the sequential Q-format matrix multiplier.
package matrix_mul_q_pkg;

  // FSM state codes
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Finalised element: saturation flag plus value (only the low W bits are meaningful)
  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } qres_t;

  // Bit offset of element (i,j) in a row-major flat matrix of n x n elements of w bits
  function automatic int idx(input int i, input int j, input int n, input int w);
    return (i * n + j) * w;
  endfunction

  // Round half up (or floor), shift out frac bits, then clamp to a signed w-bit range.
  // Widths are passed as constants so the arithmetic folds down to the real sizes.
  function automatic qres_t q_round_sat(input logic signed [127:0] sum, input logic rnd,
                                        input int w, input int frac);
    logic signed [127:0] s;
    logic signed [127:0] mx;
    logic signed [127:0] mn;
    qres_t               r;
    s = sum;
    if (rnd && frac > 0) s = s + (128'sd1 <<< (frac - 1));
    s  = s >>> frac;
    mx = (128'sd1 <<< (w - 1)) - 128'sd1;
    mn = -(128'sd1 <<< (w - 1));
    r.ovf = 1'b0;
    r.val = s[63:0];
    if (s > mx) begin
      r.ovf = 1'b1;
      r.val = mx[63:0];
    end else if (s < mn) begin
      r.ovf = 1'b1;
      r.val = mn[63:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/q_mac.sv
// Shared signed multiply-accumulate. Accumulates full-precision products; on the
// last k of an element it rounds/saturates acc+product into a registered result.
module q_mac
  import matrix_mul_q_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = 14,
  parameter int ACC_W = 2 * W + 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clr,   // start of a new matrix
  input  logic                i_en,    // one MAC step this cycle
  input  logic                i_fin,   // this step closes the current element
  input  logic                i_rnd,
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic                o_vld,
  output logic [W-1:0]        o_res,
  output logic                o_ovf
);

  logic signed [2*W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_sum;
  qres_t                   w_q;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_vld;
  logic [W-1:0]            r_res;
  logic                    r_ovf;

  assign w_prod = i_a * i_b;
  assign w_sum  = r_acc + ACC_W'(w_prod);
  assign w_q    = q_round_sat(128'(w_sum), i_rnd, W, FRAC);

  // Accumulator runs per element; finalised element is registered one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_vld <= 1'b0;
      r_res <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_vld <= i_fin;
      if (i_clr || i_fin) r_acc <= '0;
      else if (i_en)      r_acc <= w_sum;
      if (i_fin) begin
        r_res <= w_q.val[W-1:0];
        r_ovf <= w_q.ovf;
      end
    end
  end

  assign o_vld = r_vld;
  assign o_res = r_res;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/matrix_mul_q_seq.sv
// Sequential NxN signed fixed-point matrix multiply C = A*B with one shared MAC.
// Iterates i,j,k row-major; each finished element lands in C one cycle after its
// last MAC, so out_valid rises N^3+1 clocks after the accepting edge.
module matrix_mul_q_seq
  import matrix_mul_q_pkg::*;
#(
  parameter int N     = 2,
  parameter int W     = 16,
  parameter int FRAC  = 14,
  parameter int ACC_W = 2 * W + $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             round_en,
  input  logic [N*N*W-1:0] a_flat,
  input  logic [N*N*W-1:0] b_flat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] c_flat,
  output logic             ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int EW = (N > 1) ? $clog2(N * N) : 1;

  logic [1:0]         r_state;
  logic [N*N*W-1:0]   r_a, r_b, r_c;
  logic               r_rnd, r_ovf, r_last;
  logic [CW-1:0]      r_i, r_j, r_k;
  logic [EW-1:0]      r_widx;

  logic               w_accept, w_issue, w_fin;
  logic               w_kend, w_jend, w_iend;
  logic [W-1:0]       w_a_op, w_b_op, w_res;
  logic               w_res_vld, w_res_ovf;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_issue  = (r_state == S_COMP) && !r_last;
  assign w_kend   = (r_k == CW'(N - 1));
  assign w_jend   = (r_j == CW'(N - 1));
  assign w_iend   = (r_i == CW'(N - 1));
  assign w_fin    = w_issue && w_kend;
  assign w_a_op   = r_a[idx(int'(r_i), int'(r_k), N, W) +: W];
  assign w_b_op   = r_b[idx(int'(r_k), int'(r_j), N, W) +: W];

  q_mac #(.W(W), .FRAC(FRAC), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept),
    .i_en  (w_issue),
    .i_fin (w_fin),
    .i_rnd (r_rnd),
    .i_a   (w_a_op),
    .i_b   (w_b_op),
    .o_vld (w_res_vld),
    .o_res (w_res),
    .o_ovf (w_res_ovf)
  );

  // FSM, loop counters, operand capture and result collection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_rnd   <= 1'b0;
      r_ovf   <= 1'b0;
      r_last  <= 1'b0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_widx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a     <= a_flat;
          r_b     <= b_flat;
          r_rnd   <= round_en;
          r_ovf   <= 1'b0;
          r_last  <= 1'b0;
          r_i     <= '0;
          r_j     <= '0;
          r_k     <= '0;
          r_widx  <= '0;
          r_state <= S_COMP;
        end
        S_COMP: begin
          // issue side: k fastest, then j, then i; r_last stops issue after N^3 steps
          if (w_issue) begin
            if (w_kend) begin
              r_k <= '0;
              if (w_jend) begin
                r_j <= '0;
                if (w_iend) r_last <= 1'b1;
                else        r_i    <= r_i + CW'(1);
              end else begin
                r_j <= r_j + CW'(1);
              end
            end else begin
              r_k <= r_k + CW'(1);
            end
          end
          // collect side: elements arrive in row-major order, last one ends the pass
          if (w_res_vld) begin
            r_c[int'(r_widx) * W +: W] <= w_res;
            r_ovf  <= r_ovf | w_res_ovf;
            r_widx <= r_widx + EW'(1);
            if (r_widx == EW'(N * N - 1)) r_state <= S_DONE;
          end
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign c_flat    = r_c;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_matrix_mul_q_seq.sv
module tb_matrix_mul_q_seq;
  localparam int N = 2, W = 16, FRAC = 14, LAT = N * N * N + 1;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, round_en = 0, out_valid, out_ready = 0, ovf;
  logic [N*N*W-1:0] a_flat = '0, b_flat = '0, c_flat;

  int n_tests = 0, n_fail = 0;

  matrix_mul_q_seq #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .round_en(round_en), .a_flat(a_flat), .b_flat(b_flat), .out_valid(out_valid),
    .out_ready(out_ready), .c_flat(c_flat), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    bit          rnd;
    logic [63:0] c;
    bit          ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int e00, input int e01, input int e10, input int e11);
    return {16'(e11), 16'(e10), 16'(e01), 16'(e00)};
  endfunction

  // Reference: plain integer matrix product, then round/floor and clamp each element
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input bit rnd);
    logic [63:0] c = '0;
    bit          o = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint sum = 0;
        longint s;
        for (int k = 0; k < N; k++)
          sum += longint'($signed(a[(i*N+k)*W +: W])) * longint'($signed(b[(k*N+j)*W +: W]));
        if (rnd) sum += longint'(1) << (FRAC - 1);
        s = sum >>> FRAC;
        if (s > 32767)       begin s = 32767;  o = 1; end
        else if (s < -32768) begin s = -32768; o = 1; end
        c[(i*N+j)*W +: W] = 16'(s);
      end
    return {o, c};
  endfunction

  // Drive one transaction, measure latency, optionally stall, then hand off
  task automatic run_txn(input logic [63:0] a, input logic [63:0] b, input bit rnd, input int hold,
                         output logic [63:0] c, output bit o, output int lat);
    @(negedge clk);
    a_flat = a; b_flat = b; round_en = rnd; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    c = c_flat; o = ovf;
    repeat (hold) @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("handoff_out_valid", out_valid, 0);
    chk("handoff_in_ready", in_ready, 1);
  endtask

  vec_t        tv[7];
  logic [63:0] c, a, b, cs;
  logic [64:0] m;
  bit          o;
  int          lat;

  initial begin
    tv[0] = '{"identity", pk(16384, 0, 0, 16384), pk(8192, 4096, 2048, -8192), 1,
              pk(8192, 4096, 2048, -8192), 0};
    tv[1] = '{"mixed", pk(8192, 8192, -8192, 8192), pk(8192, -8192, 8192, 8192), 1,
              pk(8192, 0, 0, 8192), 0};
    tv[2] = '{"sat_pos", pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767), 1,
              pk(32767, 32767, 32767, 32767), 1};
    tv[3] = '{"sat_neg", pk(-32768, -32768, -32768, -32768), pk(32767, 32767, 32767, 32767), 0,
              pk(-32768, -32768, -32768, -32768), 1};
    tv[4] = '{"rnd_pos", pk(1, 0, 0, 0), pk(8192, 0, 0, 0), 1, pk(1, 0, 0, 0), 0};
    tv[5] = '{"trunc_pos", pk(1, 0, 0, 0), pk(8192, 0, 0, 0), 0, pk(0, 0, 0, 0), 0};
    tv[6] = '{"trunc_neg", pk(-1, 0, 0, 0), pk(8192, 0, 0, 0), 0, pk(-1, 0, 0, 0), 0};

    // reset values
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c_flat", c_flat, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk) rst_n = 1;

    // directed table
    for (int t = 0; t < 7; t++) begin
      run_txn(tv[t].a, tv[t].b, tv[t].rnd, 0, c, o, lat);
      chk({tv[t].name, "_c"}, c, tv[t].c);
      chk({tv[t].name, "_ovf"}, o, tv[t].ovf);
      chk({tv[t].name, "_lat"}, lat, LAT);
    end
    // round-half-up with negative operand
    run_txn(pk(-1, 0, 0, 0), pk(8192, 0, 0, 0), 1, 0, c, o, lat);
    chk("rnd_neg_c", c, 0);

    // backpressure: stall 5 cycles while poking inputs
    @(negedge clk);
    a_flat = tv[1].a; b_flat = tv[1].b; round_en = 1; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bp_lat", lat, LAT);
    cs = c_flat;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      in_valid = ~in_valid; a_flat = {$urandom, $urandom}; b_flat = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("bp_c_stable", c_flat, cs);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    chk("bp_c_value", c_flat, tv[1].c);
    @(negedge clk) in_valid = 0; out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    chk("bp_release_ov", out_valid, 0);
    chk("bp_release_ir", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_single_handoff", out_valid, 0);
    chk("bp_no_accept", in_ready, 1);

    // reset in the middle of COMP (c_flat currently holds a non-zero result)
    @(negedge clk);
    a_flat = tv[2].a; b_flat = tv[2].b; round_en = 1; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_c_flat", c_flat, 0);
    chk("midrst_ovf", ovf, 0);
    @(negedge clk) rst_n = 1;
    run_txn(tv[1].a, tv[1].b, 1, 0, c, o, lat);
    chk("postrst_c", c, tv[1].c);
    chk("postrst_lat", lat, LAT);

    // randomized against the reference model
    for (int r = 0; r < 40; r++) begin
      bit rnd;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (r % 4 == 0) a = a >> ($urandom_range(0, 3) * 4);
      rnd = 1'($urandom_range(0, 1));
      m = model(a, b, rnd);
      run_txn(a, b, rnd, $urandom_range(0, 3), c, o, lat);
      chk("rand_c", c, m[63:0]);
      chk("rand_ovf", o, m[64]);
      chk("rand_lat", lat, LAT);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
